// File: rtl/adc0832_data_receiver.sv
// -----------------------------------------------------------------------------
// adc0832_data_receiver
//
// Serial-data capture stage that sits behind the ADC0832 command sequencer.
// Once the sequencer signals that the command phase is over (read_en high),
// the receiver discards the converter's null bit(s), then shifts in the
// MSB-first conversion result. Optionally, it also checks the LSB-first trailer
// that the ADC0832 repeats after the result. The captured word is presented on
// data_out together with a one-cycle data_valid strobe.
//
// Optional feature macro: ADC_LSB_CHECK_EN
//   defined   : an LSB state receives the DATA_WIDTH-1 trailer bits (B1..B(W-1)).
//               Any trailer bit that differs from the captured word sets
//               data_error on that conversion's valid pulse.
//   undefined : there is no LSB state. The receiver goes from MSB straight to
//               DONE, ignores the trailer, and data_error is tied low.
//
// Parameters
//   DATA_WIDTH   conversion width in bits (>= 3)
//   NULL_BITS    DO cycles discarded before the first data bit (1..3)
//   COUNT_WIDTH  width of the completed-conversion counter
//
// Ports
//   clk         ADC serial clock; adc_do is sampled on the rising edge
//   reset       asynchronous, active-high reset
//   read_en     high while DO carries conversion data; low once CS is released
//   adc_do      ADC0832 DO line
//   data_out    last captured sample (MSB-first word)
//   data_valid  one-cycle pulse: data_out/data_error were just updated
//   data_error  LSB trailer mismatch on the last completed conversion
//   busy        high while in the NULL, MSB or LSB state
//   conv_count  number of completed conversions, wraps modulo 2^COUNT_WIDTH
// -----------------------------------------------------------------------------
module adc0832_data_receiver #(
  parameter int DATA_WIDTH  = 8,
  parameter int NULL_BITS   = 1,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   read_en,
  input  logic                   adc_do,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   data_valid,
  output logic                   data_error,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] conv_count
);

  // The bit counter must hold the largest per-state count: NULL_BITS-1 in
  // NULL, or DATA_WIDTH-1 in MSB.
  localparam int CNT_W = $clog2(DATA_WIDTH + NULL_BITS + 1);

`ifdef ADC_LSB_CHECK_EN
  // The full word is kept so that the trailer can be compared against it.
  localparam int SR_W  = DATA_WIDTH;
  localparam int IDX_W = $clog2(DATA_WIDTH);
`else
  // Without the trailer check, the final MSB bit goes straight into data_out.
  // Only DATA_WIDTH-1 bits therefore need to be held in the shift register.
  localparam int SR_W  = DATA_WIDTH - 1;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_NULL,
    S_MSB,
    S_LSB,
    S_DONE
  } state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      bit_cnt;
  logic [SR_W-1:0]       shift_reg;
  logic                  last_bit;   // this edge samples the conversion's final bit
  logic [DATA_WIDTH-1:0] word_nxt;   // word that is loaded into data_out on completion

`ifdef ADC_LSB_CHECK_EN
  logic [IDX_W-1:0]      lsb_idx;
  logic                  lsb_mismatch;
  logic                  err_acc;    // sticky mismatch flag within one trailer

  // Trailer bit k (k = 0..W-2) carries data bit B(k+1).
  assign lsb_idx      = IDX_W'(bit_cnt + CNT_W'(1));
  assign lsb_mismatch = adc_do ^ shift_reg[lsb_idx];
  assign word_nxt     = shift_reg;
`else
  assign word_nxt     = {shift_reg, adc_do};
`endif

  // NOTE: the reset is asynchronous, so it sits in the sensitivity list.
  // Every register is cleared without waiting for a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: defaults are assigned first so that no path through the case
  // leaves an output unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    last_bit  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (read_en) state_nxt = S_NULL;
      end
      S_NULL: begin
        if (!read_en)                             state_nxt = S_IDLE;
        else if (bit_cnt == CNT_W'(NULL_BITS - 1)) state_nxt = S_MSB;
      end
      S_MSB: begin
        if (!read_en) begin
          state_nxt = S_IDLE;
        end else if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
`ifdef ADC_LSB_CHECK_EN
          state_nxt = S_LSB;
`else
          state_nxt = S_DONE;
          last_bit  = 1'b1;
`endif
        end
      end
      S_LSB: begin
        if (!read_en) begin
          state_nxt = S_IDLE;
        end else if (bit_cnt == CNT_W'(DATA_WIDTH - 2)) begin
          state_nxt = S_DONE;
          last_bit  = 1'b1;
        end
      end
      S_DONE: begin
        // Hold here while read_en stays high, so a long CS window cannot
        // produce a second conversion.
        if (!read_en) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: all sequential state is updated with non-blocking assignments.
  // Every register therefore sees the pre-edge values of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt    <= '0;
      shift_reg  <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      conv_count <= '0;
`ifdef ADC_LSB_CHECK_EN
      err_acc    <= 1'b0;
      data_error <= 1'b0;
`endif
    end else begin
      data_valid <= last_bit;
      busy       <= (state_nxt == S_NULL) || (state_nxt == S_MSB) ||
                    (state_nxt == S_LSB);

      // The bit counter restarts on every state change. It counts only inside
      // the bit-consuming states.
      if ((state_nxt != state) || (state_nxt == S_IDLE) || (state_nxt == S_DONE))
        bit_cnt <= '0;
      else
        bit_cnt <= bit_cnt + CNT_W'(1);

      if ((state == S_IDLE) && (state_nxt == S_NULL)) begin
        shift_reg <= '0;
`ifdef ADC_LSB_CHECK_EN
        err_acc   <= 1'b0;
`endif
      end else if ((state == S_MSB) && read_en) begin
        shift_reg <= {shift_reg[SR_W-2:0], adc_do};
      end

`ifdef ADC_LSB_CHECK_EN
      if ((state == S_LSB) && read_en)
        err_acc <= err_acc | lsb_mismatch;
`endif

      if (last_bit) begin
        data_out   <= word_nxt;
        conv_count <= conv_count + COUNT_WIDTH'(1);
`ifdef ADC_LSB_CHECK_EN
        data_error <= err_acc | lsb_mismatch;
`endif
      end
    end
  end

`ifndef ADC_LSB_CHECK_EN
  assign data_error = 1'b0;
`endif

endmodule

// File: tb/tb_adc0832_data_receiver.sv
// -----------------------------------------------------------------------------
// tb_adc0832_data_receiver
//
// Self-checking bench for adc0832_data_receiver. Each conversion is described
// at the transaction level: the word, a trailer corruption mask, an optional
// abort edge, an optional reset edge, and a hold time. The expected latency,
// error flag and counter values come from the arithmetic rules of the receiver.
// A second instance with a 3-bit counter exercises counter wrap-around.
// -----------------------------------------------------------------------------
module tb_adc0832_data_receiver;

  localparam int DW   = 8;
  localparam int NB   = 1;
  localparam int CW   = 16;
  localparam int CW_S = 3;

`ifdef ADC_LSB_CHECK_EN
  localparam bit LSB_ON = 1'b1;
`else
  localparam bit LSB_ON = 1'b0;
`endif

  // Edge number (arming edge = #0) on which the final bit is sampled.
  localparam int LAT = LSB_ON ? (NB + 2 * DW - 1) : (NB + DW);

  logic            clk = 1'b0;
  logic            reset;
  logic            read_en;
  logic            adc_do;
  logic [DW-1:0]   data_out;
  logic            data_valid;
  logic            data_error;
  logic            busy;
  logic [CW-1:0]   conv_count;
  logic [DW-1:0]   s_data_out;
  logic            s_data_valid;
  logic            s_data_error;
  logic            s_busy;
  logic [CW_S-1:0] s_conv_count;

  adc0832_data_receiver #(.DATA_WIDTH(DW), .NULL_BITS(NB), .COUNT_WIDTH(CW)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .read_en    (read_en),
    .adc_do     (adc_do),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_error (data_error),
    .busy       (busy),
    .conv_count (conv_count)
  );

  adc0832_data_receiver #(.DATA_WIDTH(DW), .NULL_BITS(NB), .COUNT_WIDTH(CW_S)) u_dut_small (
    .clk        (clk),
    .reset      (reset),
    .read_en    (read_en),
    .adc_do     (adc_do),
    .data_out   (s_data_out),
    .data_valid (s_data_valid),
    .data_error (s_data_error),
    .busy       (s_busy),
    .conv_count (s_conv_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_bad    = 0;

  // Reference model: the last completed result and the completions since reset.
  logic [DW-1:0] m_out;
  logic          m_err;
  int            m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] cnt_mod(input int n, input int w);
    return 32'(n) & ((32'd1 << w) - 32'd1);
  endfunction

  task automatic check_model(input string tag);
    check({tag, ".data_out"},   32'(data_out),     32'(m_out));
    check({tag, ".data_error"}, 32'(data_error),   32'(m_err));
    check({tag, ".conv_count"}, 32'(conv_count),   cnt_mod(m_cnt, CW));
    check({tag, ".s_count"},    32'(s_conv_count), cnt_mod(m_cnt, CW_S));
  endtask

  // Runs one conversion, starting from IDLE with read_en low.
  //   flip       : bit k inverts trailer bit B(k+1)
  //   abort_edge : edge at which read_en is first sampled low (0 = never)
  //   reset_edge : reset is asserted just before this edge (0 = never)
  //   hold       : extra cycles that read_en stays high after completion
  task automatic do_conv(input logic [DW-1:0] word, input logic [DW-2:0] flip,
                         input int abort_edge, input int reset_edge, input int hold);
    logic stream[$];
    int   pulses;
    int   pulse_edge;
    int   prev;
    bit   aborted;
    bit   exp_busy;
    logic exp_err;
    pulses     = 0;
    pulse_edge = -1;
    aborted    = (abort_edge >= 1) && (abort_edge <= LAT);
    exp_err    = LSB_ON && (flip != '0);
    for (int i = 0; i < NB; i++)      stream.push_back(1'($urandom_range(0, 1)));
    for (int i = DW - 1; i >= 0; i--) stream.push_back(word[i]);
    for (int i = 1; i < DW; i++)      stream.push_back(word[i] ^ flip[i-1]);

    @(negedge clk);
    read_en = 1'b1;
    adc_do  = 1'($urandom_range(0, 1));
    for (int e = 1; e <= LAT + hold + 2; e++) begin
      @(negedge clk);
      prev     = e - 1;
      exp_busy = (prev < LAT) && !(abort_edge > 0 && prev >= abort_edge);
      check("busy",   32'(busy),   32'(exp_busy));
      check("s_busy", 32'(s_busy), 32'(exp_busy));
      check("s_valid_match", 32'(s_data_valid), 32'(data_valid));
      if (data_valid) begin
        pulses++;
        pulse_edge = prev;
        check("pulse.data_out",   32'(data_out),     32'(word));
        check("pulse.data_error", 32'(data_error),   32'(exp_err));
        check("pulse.conv_count", 32'(conv_count),   cnt_mod(m_cnt + 1, CW));
        check("pulse.s_count",    32'(s_conv_count), cnt_mod(m_cnt + 1, CW_S));
        check("pulse.s_data_out", 32'(s_data_out),   32'(word));
        check("pulse.s_error",    32'(s_data_error), 32'(exp_err));
      end
      if (e == reset_edge) begin
        reset = 1'b1;
        #1;
        check("rst.data_out",   32'(data_out),     32'd0);
        check("rst.data_valid", 32'(data_valid),   32'd0);
        check("rst.data_error", 32'(data_error),   32'd0);
        check("rst.busy",       32'(busy),         32'd0);
        check("rst.conv_count", 32'(conv_count),   32'd0);
        check("rst.s_count",    32'(s_conv_count), 32'd0);
        m_out = '0;
        m_err = 1'b0;
        m_cnt = 0;
        @(negedge clk);
        reset   = 1'b0;
        read_en = 1'b0;
        return;
      end
      read_en = !(abort_edge > 0 && e >= abort_edge);
      adc_do  = (e - 1 < stream.size()) ? stream[e-1] : 1'($urandom_range(0, 1));
    end

    check("pulse_count", 32'(pulses), aborted ? 32'd0 : 32'd1);
    if (!aborted) begin
      check("valid_edge", 32'(pulse_edge), 32'(LAT));
      m_out = word;
      m_err = exp_err;
      m_cnt++;
    end
    check_model("after");
    @(negedge clk);
    read_en = 1'b0;
  endtask

  initial begin
    logic [DW-1:0]   r_word;
    logic [DW-2:0]   r_flip;
    int              r_abort;
    reset   = 1'b1;
    read_en = 1'b0;
    adc_do  = 1'b0;
    m_out   = '0;
    m_err   = 1'b0;
    m_cnt   = 0;
    repeat (3) @(negedge clk);
    check("init.data_valid", 32'(data_valid), 32'd0);
    check("init.busy",       32'(busy),       32'd0);
    check_model("init");
    reset = 1'b0;
    @(negedge clk);

    do_conv(8'hA5, 7'b0000000, 0, 0, 2);           // clean capture
    do_conv(8'hA5, 7'b0000100, 0, 0, 2);           // trailer bit B3 corrupted
    do_conv(8'h3C, 7'b0000000, 0, 0, 2);           // clean capture clears the error
    do_conv(8'h5A, 7'b0000000, NB + 6, 0, 2);      // abort after 5 MSB bits
    do_conv(8'hC3, 7'b0000000, 0, NB + 5, 2);      // reset after 4 MSB bits
    do_conv(8'h96, 7'b0000000, 0, 0, 2);           // clean capture after reset
    do_conv(8'hF0, 7'b0000000, 0, 0, 40);          // long read_en hold: one pulse

    for (int n = 0; n < 24; n++) begin
      r_word  = DW'($urandom);
      r_flip  = ($urandom_range(0, 1) == 0) ? '0 : (DW-1)'($urandom);
      r_abort = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, LAT)) : 0;
      do_conv(r_word, r_flip, r_abort, 0, int'($urandom_range(1, 4)));
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
